// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the host-link UART.
//   uart_rx_state_t : receiver FSM states
//   DATA_BITS       : payload bits per 8N1 frame
//   clks_per_bit()  : clock cycles per bit period (truncated), shared with the TXD serialiser
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous pin inputs.
// Ports:
//   clk   : destination clock
//   reset : asynchronous active-high reset, both stages load RESET_VAL
//   d     : asynchronous input
//   q     : synchronised output (2 cycles of latency)
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 serial receiver with a valid/ready byte output.
// Ports:
//   clk        : system clock
//   reset      : asynchronous active-high reset
//   rxd        : raw serial input (asynchronous, idles high)
//   dout       : received byte, bit 0 = first data bit on the wire
//   dout_valid : dout holds an unconsumed byte
//   dout_ready : consumer accepts dout when high together with dout_valid
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, completed byte dropped because dout was still held
//   busy       : receiver is not idle
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD        = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW           = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  // First sample lands mid start bit, every later one a full bit period on.
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("uart_byte_rx: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  // ---------------------------------------------------------------
  // Input synchronisation and falling-edge detection
  // ---------------------------------------------------------------
  logic rxd_s;
  logic rxd_d_reg;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_rxd_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rxd),
    .q     (rxd_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rxd_d_reg <= 1'b1;
    else       rxd_d_reg <= rxd_s;
  end

  // ---------------------------------------------------------------
  // Receive FSM, bit timer, shift register
  // ---------------------------------------------------------------
  uart_rx_state_t state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [IW-1:0]  bit_idx_reg, bit_idx_next;
  logic [7:0]     shift_reg, shift_next;
  logic           sample;
  logic           byte_done;
  logic           stop_bad;

  assign sample = (cnt_reg == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = sample ? CNT_FULL : cnt_reg - 1'b1;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    byte_done    = 1'b0;
    stop_bad     = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = CNT_FULL;
        if (rxd_d_reg && !rxd_s) begin
          state_next = START;
          cnt_next   = CNT_HALF;
        end
      end

      START: begin
        if (sample) begin
          if (!rxd_s) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_next = IDLE;
          end
        end
      end

      DATA: begin
        if (sample) begin
          shift_next = {rxd_s, shift_reg[7:1]};
          if (bit_idx_reg == IDX_LAST) state_next = STOP;
          else                         bit_idx_next = bit_idx_reg + 1'b1;
        end
      end

      STOP: begin
        if (sample) begin
          if (rxd_s) begin
            byte_done  = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = WAIT_HIGH;
          end
        end
      end

      WAIT_HIGH: begin
        // Hold off until the line idles so a break is not seen as many frames.
        cnt_next = CNT_FULL;
        if (rxd_s) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Output register: byte handoff and status pulses
  // ---------------------------------------------------------------
  logic [7:0] dout_reg;
  logic       dout_valid_reg;
  logic       frame_err_reg;
  logic       overrun_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      frame_err_reg <= stop_bad;
      overrun_reg   <= byte_done && dout_valid_reg && !dout_ready;
      // A byte being consumed this cycle frees the slot for a coinciding delivery.
      if (byte_done && (!dout_valid_reg || dout_ready)) begin
        dout_reg       <= shift_reg;
        dout_valid_reg <= 1'b1;
      end else if (dout_valid_reg && dout_ready) begin
        dout_valid_reg <= 1'b0;
      end
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign frame_err  = frame_err_reg;
  assign overrun    = overrun_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed bench for uart_byte_rx at 16 clocks per bit.
module tb_uart_byte_rx;

  localparam int BIT_CLKS = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_byte_rx #(
    .CLK_FREQ_HZ (1600000),
    .BAUD        (100000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  // ---------------- monitor (samples on falling edge) ----------------
  int         cyc = 0;
  int         rise_cyc = 0;
  int         run = 0;
  int         last_run = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] deliv [0:63];
  int         deliv_n = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         both_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dout_valid && !valid_prev) rise_cyc = cyc;
    if (dout_valid) run = run + 1;
    else if (valid_prev) begin
      last_run = run;
      run = 0;
    end
    valid_prev = dout_valid;
    if (dout_valid && dout_ready && deliv_n < 64) begin
      deliv[deliv_n] = dout;
      deliv_n = deliv_n + 1;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (overrun) ov_cnt = ov_cnt + 1;
    if (frame_err && overrun) both_cnt = both_cnt + 1;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (BIT_CLKS) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT_CLKS) tick();
    end
    rxd = stop_bit;
    repeat (BIT_CLKS) tick();
  endtask

  int base_d, base_fe, base_ov, start_cyc, lat;
  logic [7:0] b96;

  initial begin
    reset      = 1'b1;
    rxd        = 1'b1;
    dout_ready = 1'b1;
    repeat (3) tick();
    chk("rst_dout", dout, 8'h00);
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (5) tick();

    // ---- single frame 0xA5 with latency ----
    base_d = deliv_n; base_fe = fe_cnt; base_ov = ov_cnt;
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1);
    repeat (8) tick();
    lat = rise_cyc - start_cyc;
    $display("frame A5: deliveries=%0d latency=%0d", deliv_n - base_d, lat);
    chk("a5_count", deliv_n - base_d, 1);
    chk("a5_data", deliv[base_d], 8'hA5);
    chk("a5_valid_len", last_run, 1);
    chk("a5_latency_ok", (lat >= 155 && lat <= 157), 1'b1);
    chk("a5_flags", (fe_cnt - base_fe) + (ov_cnt - base_ov), 0);
    chk("a5_idle", busy, 1'b0);

    // ---- back-to-back 0x00, 0xFF, 0x55 ----
    base_d = deliv_n; base_fe = fe_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    repeat (8) tick();
    $display("back-to-back: deliveries=%0d", deliv_n - base_d);
    chk("b2b_count", deliv_n - base_d, 3);
    chk("b2b_d0", deliv[base_d], 8'h00);
    chk("b2b_d1", deliv[base_d + 1], 8'hFF);
    chk("b2b_d2", deliv[base_d + 2], 8'h55);
    chk("b2b_frame_err", fe_cnt - base_fe, 0);

    // ---- framing error, long break, recovery ----
    base_d = deliv_n; base_fe = fe_cnt; base_ov = ov_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (40 * BIT_CLKS) tick();
    chk("break_busy", busy, 1'b1);
    rxd = 1'b1;
    repeat (2 * BIT_CLKS) tick();
    chk("break_release_idle", busy, 1'b0);
    send_frame(8'h81, 1'b1);
    repeat (8) tick();
    $display("frame error: fe_pulses=%0d deliveries=%0d", fe_cnt - base_fe, deliv_n - base_d);
    chk("fe_pulses", fe_cnt - base_fe, 1);
    chk("fe_count", deliv_n - base_d, 1);
    chk("fe_next_data", deliv[base_d], 8'h81);
    chk("fe_no_overrun", ov_cnt - base_ov, 0);

    // ---- glitch shorter than half a bit ----
    base_d = deliv_n; base_fe = fe_cnt; base_ov = ov_cnt;
    rxd = 1'b0;
    repeat (5) tick();
    rxd = 1'b1;
    chk("glitch_busy_high", busy, 1'b1);
    repeat (20) tick();
    $display("glitch: busy=%0b deliveries=%0d", busy, deliv_n - base_d);
    chk("glitch_busy_low", busy, 1'b0);
    chk("glitch_no_data", deliv_n - base_d, 0);
    chk("glitch_no_flags", (fe_cnt - base_fe) + (ov_cnt - base_ov), 0);

    // ---- overrun with consumer stalled ----
    base_d = deliv_n; base_ov = ov_cnt;
    dout_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (8) tick();
    $display("overrun: dout=%02h valid=%0b ov_pulses=%0d", dout, dout_valid, ov_cnt - base_ov);
    chk("ovr_hold_data", dout, 8'h11);
    chk("ovr_hold_valid", dout_valid, 1'b1);
    chk("ovr_pulses", ov_cnt - base_ov, 1);
    dout_ready = 1'b1;
    tick();
    tick();
    chk("ovr_accept_count", deliv_n - base_d, 1);
    chk("ovr_accept_data", deliv[base_d], 8'h11);
    chk("ovr_valid_clear", dout_valid, 1'b0);

    // ---- reset during bit 4 of 0x96, then resend ----
    b96 = 8'h96;
    rxd = 1'b0;
    repeat (BIT_CLKS) tick();
    for (int i = 0; i < 4; i++) begin
      rxd = b96[i];
      repeat (BIT_CLKS) tick();
    end
    rxd = b96[4];
    repeat (BIT_CLKS / 2) tick();
    chk("mid_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_dout", dout, 8'h00);
    chk("mid_rst_valid", dout_valid, 1'b0);
    rxd = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2 * BIT_CLKS) tick();
    base_d = deliv_n; base_fe = fe_cnt;
    send_frame(8'h96, 1'b1);
    repeat (8) tick();
    $display("reset recovery: deliveries=%0d", deliv_n - base_d);
    chk("rst_resend_count", deliv_n - base_d, 1);
    chk("rst_resend_data", deliv[base_d], 8'h96);
    chk("rst_resend_fe", fe_cnt - base_fe, 0);
    chk("never_both_flags", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
